// File: rtl/fifo_uart_tx_if.sv
// Purpose: bundles the FIFO-read handshake and the UART line/status outputs of fifo_uart_tx.
// Ports:   master = transmitter side (reads FIFO, drives tx/busy/frame_done);
//          slave  = environment side (provides enable and FIFO flags/data).
interface fifo_uart_tx_if;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       frame_done;

    modport master (
        input  enable, fifo_empty, fifo_data,
        output fifo_rd_en, tx, busy, frame_done
    );

    modport slave (
        output enable, fifo_empty, fifo_data,
        input  fifo_rd_en, tx, busy, frame_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Purpose: pops bytes from a 1-cycle-latency FIFO and sends each as an 8N1/8E1/8O1 frame, LSB first.
// Latency: empty seen low in IDLE at edge N -> rd_en during cycle N+1 -> capture at N+2 -> tx falls at N+3.
// Backpressure: a new frame starts only when enable is high and the FIFO is non-empty while idle.
// Ports: clk, rst (async, active high); bus (master modport): enable, fifo_empty, fifo_data in;
//        fifo_rd_en, tx (registered, idle high), busy, frame_done (registered) out.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic          clk,
    input  logic          rst,
    fifo_uart_tx_if.master bus
);

    localparam int             BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic           PAR_ODD   = (PARITY_ODD != 0);
    localparam logic           PAR_ON    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
    } state_t;

    state_t         state, state_next;
    logic [BW-1:0]  baud_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic           parity_bit;
    logic           tx_q, done_q;
    logic           tx_next, done_next, bit_end;

    // tx and frame_done are registered from the current state, so the line
    // trails the state register by one cycle; every bit still lasts exactly
    // CLKS_PER_BIT cycles and frame_done lines up with the last stop cycle on tx.
    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        done_next  = 1'b0;
        bit_end    = (baud_cnt == BAUD_LAST);
        case (state)
            IDLE: begin
                if (bus.enable && !bus.fifo_empty) state_next = FETCH;
            end
            FETCH:  state_next = LOAD;
            LOAD:   state_next = START;
            START: begin
                tx_next = 1'b0;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (bit_end && bit_cnt == 3'd7) state_next = PAR_ON ? PARITY : STOP;
            end
            PARITY: begin
                tx_next = parity_bit;
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end && bit_cnt == STOP_LAST) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            state  <= state_next;
            tx_q   <= tx_next;
            done_q <= done_next;

            // Counters restart on every state entry; bit_cnt tracks data bits in
            // DATA and stop-bit index in STOP.
            if (state_next != state) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (bit_end) begin
                baud_cnt <= '0;
                bit_cnt  <= bit_cnt + 3'd1;
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end

            if (state == LOAD) begin
                shift_reg  <= bus.fifo_data;
                parity_bit <= (^bus.fifo_data) ^ PAR_ODD;
            end else if (state == DATA && bit_end) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
            end
        end
    end

    assign bus.fifo_rd_en = (state == FETCH);
    assign bus.busy       = (state != IDLE);
    assign bus.tx         = tx_q;
    assign bus.frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

    localparam int NI = 3;
    // Three configurations: 8N1, 8E1, 8O2 (CLKS_PER_BIT 4, 4, 3).
    localparam int CPB_T [NI] = '{4, 4, 3};
    localparam int PE_T  [NI] = '{0, 1, 1};
    localparam int PO_T  [NI] = '{0, 0, 1};
    localparam int SB_T  [NI] = '{1, 1, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       push_vld = 1'b0;
    logic [7:0] push_dat = 8'h00;

    logic tx_w [NI];
    logic busy_w [NI];
    logic rd_w [NI];
    logic done_w [NI];
    int   rd_cnt [NI];
    int   fq_n [NI];
    int   exq_n [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int inst, input logic ok, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s inst%0d: got 0x%0h want 0x%0h", name, inst, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int CPB = CPB_T[g];
        localparam int PE  = PE_T[g];
        localparam int PO  = PO_T[g];
        localparam int SB  = SB_T[g];
        localparam int L   = (9 + PE + SB) * CPB;

        fifo_uart_tx_if bus();
        logic       empty_r = 1'b1;
        logic [7:0] data_r = 8'h00;
        logic [7:0] fq[$];
        logic [7:0] exq[$];

        assign bus.enable     = enable;
        assign bus.fifo_empty = empty_r;
        assign bus.fifo_data  = data_r;
        assign tx_w[g]   = bus.tx;
        assign busy_w[g] = bus.busy;
        assign rd_w[g]   = bus.fifo_rd_en;
        assign done_w[g] = bus.frame_done;

        fifo_uart_tx #(
            .CLKS_PER_BIT(CPB), .PARITY_EN(PE), .PARITY_ODD(PO), .STOP_BITS(SB)
        ) dut (
            .clk(clk), .rst(rst), .bus(bus)
        );

        // FIFO model: one-cycle read latency, data_out zero when not reading.
        // Every pushed byte is also queued as an expected frame.
        always @(posedge clk) begin
            if (push_vld) begin
                fq.push_back(push_dat);
                exq.push_back(push_dat);
            end
            if (bus.fifo_rd_en && fq.size() > 0) data_r <= fq.pop_front();
            else                                 data_r <= 8'h00;
            empty_r <= (fq.size() == 0);
        end

        // Line level expected during bit period bi of a frame carrying b.
        function automatic logic exp_bit(input logic [7:0] b, input int bi);
            if (bi == 0)              return 1'b0;
            if (bi <= 8)              return b[bi-1];
            if (PE != 0 && bi == 9)   return (^b) ^ (PO != 0);
            return 1'b1;
        endfunction

        logic       in_frame = 1'b0;
        logic       inflight = 1'b0;
        logic       armed = 1'b0;
        logic       after_end = 1'b0;
        int         pos = 0;
        int         since_rd = -1;
        int         gap = 0;
        int         bad_tx = 0;
        int         bad_ctl = 0;
        logic [7:0] eb = 8'h00;
        logic [7:0] ab = 8'h00;

        initial rd_cnt[g] = 0;

        always @(negedge clk) begin
            if (rst) begin
                // An interrupted frame loses its byte.
                if (inflight && exq.size() > 0) eb = exq.pop_front();
                inflight = 1'b0; in_frame = 1'b0; armed = 1'b0;
                after_end = 1'b0; since_rd = -1; gap = 0;
            end else begin
                if (rd_w[g]) begin
                    rd_cnt[g]++;
                    chk("rd_once_per_frame", g, !inflight, int'(inflight), 0);
                    chk("rd_fifo_nonempty", g, fq.size() > 0 || data_r != 8'h00 || exq.size() > 0, exq.size(), 1);
                    inflight = 1'b1;
                    since_rd = 0;
                end else if (since_rd >= 0) begin
                    since_rd++;
                end

                if (after_end) begin
                    chk("done_one_cycle", g, !done_w[g], int'(done_w[g]), 0);
                    after_end = 1'b0;
                end

                if (!in_frame) begin
                    if (!tx_w[g]) begin
                        in_frame = 1'b1;
                        pos = 0; bad_tx = 0; bad_ctl = 0; ab = 8'h00;
                        chk("start_latency", g, since_rd == 3, since_rd, 3);
                        if (armed) chk("frame_gap", g, gap == 3, gap, 3);
                        armed = 1'b0;
                        chk("frame_expected", g, exq.size() > 0, exq.size(), 1);
                        eb = (exq.size() > 0) ? exq[0] : 8'h00;
                    end else begin
                        gap++;
                        if (armed && gap > 3) begin
                            chk("frame_gap", g, 1'b0, gap, 3);
                            armed = 1'b0;
                        end
                    end
                end

                if (in_frame) begin
                    if (tx_w[g] !== exp_bit(eb, pos / CPB)) bad_tx++;
                    if (pos % CPB == CPB / 2 && pos / CPB >= 1 && pos / CPB <= 8)
                        ab[pos / CPB - 1] = tx_w[g];
                    if (done_w[g] !== (pos == L - 1)) bad_ctl++;
                    if (pos < L - 1 && busy_w[g] !== 1'b1) bad_ctl++;
                    pos++;
                    if (pos == L) begin
                        if (bad_tx != 0)
                            $display("  inst%0d frame byte 0x%0h decoded as 0x%0h", g, eb, ab);
                        chk("frame_bits", g, bad_tx == 0, bad_tx, 0);
                        chk("frame_done_busy", g, bad_ctl == 0, bad_ctl, 0);
                        if (exq.size() > 0) eb = exq.pop_front();
                        inflight = 1'b0; in_frame = 1'b0; after_end = 1'b1;
                        gap = 0; since_rd = -1;
                        armed = (fq.size() > 0) && enable;
                    end
                end
            end
            fq_n[g]  = fq.size();
            exq_n[g] = exq.size();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        push_vld = 1'b1;
        push_dat = b;
        tick();
        push_vld = 1'b0;
    endtask

    function automatic logic all_idle();
        for (int i = 0; i < NI; i++)
            if (fq_n[i] != 0 || exq_n[i] != 0 || busy_w[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string name);
        int k;
        for (k = 0; k < 6000; k++) begin
            tick();
            if (all_idle()) break;
        end
        chk(name, 0, all_idle(), k, 0);
        for (int i = 0; i < NI; i++) chk("idle_tx_high", i, tx_w[i] === 1'b1, int'(tx_w[i]), 1);
    endtask

    task automatic wait_tx_fall();
        int k;
        for (k = 0; k < 200 && tx_w[0] === 1'b1; k++) tick();
        chk("tx_fall_seen", 0, tx_w[0] === 1'b0, k, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        for (int i = 0; i < NI; i++) begin
            chk({name, "_tx"},   i, tx_w[i]   === 1'b1, int'(tx_w[i]), 1);
            chk({name, "_busy"}, i, busy_w[i] === 1'b0, int'(busy_w[i]), 0);
            chk({name, "_rd"},   i, rd_w[i]   === 1'b0, int'(rd_w[i]), 0);
            chk({name, "_done"}, i, done_w[i] === 1'b0, int'(done_w[i]), 0);
        end
    endtask

    int base [NI];

    initial begin
        repeat (3) tick();
        check_reset_outputs("por");
        rst = 1'b0;
        repeat (3) tick();

        // Asynchronous reset pulse while idle.
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_idle");
        tick();
        rst = 1'b0;
        tick();

        // enable low: a waiting byte must not be fetched.
        enable = 1'b0;
        for (int i = 0; i < NI; i++) base[i] = rd_cnt[i];
        push_byte(8'hA5);
        repeat (100) tick();
        for (int i = 0; i < NI; i++) begin
            chk("no_rd_when_disabled", i, rd_cnt[i] == base[i], rd_cnt[i] - base[i], 0);
            chk("idle_busy_low", i, busy_w[i] === 1'b0, int'(busy_w[i]), 0);
        end

        // Directed bytes then random ones, back to back.
        enable = 1'b1;
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h3C);
        push_byte(8'h07);
        push_byte(8'h03);
        for (int n = 0; n < 8; n++) push_byte(8'($urandom));
        drain("drain_burst");

        // Drop enable in the middle of a frame.
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        wait_tx_fall();
        repeat (10) tick();
        enable = 1'b0;
        for (int i = 0; i < NI; i++) base[i] = rd_cnt[i];
        repeat (200) tick();
        for (int i = 0; i < NI; i++) begin
            chk("no_rd_after_disable", i, rd_cnt[i] == base[i], rd_cnt[i] - base[i], 0);
            chk("frame_finished_disabled", i, exq_n[i] == 2, exq_n[i], 2);
            chk("busy_low_disabled", i, busy_w[i] === 1'b0, int'(busy_w[i]), 0);
        end
        enable = 1'b1;
        drain("drain_reenable");

        // Reset during data bit 4, then a fresh frame after release.
        push_byte(8'h5A);
        wait_tx_fall();
        repeat (5 * CPB_T[0] + 1) tick();
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid_frame");
        push_byte(8'hC3);
        tick();
        rst = 1'b0;
        drain("drain_after_reset");

        // Random traffic with random enable toggling.
        for (int n = 0; n < 16; n++) begin
            push_byte(8'($urandom));
            if ($urandom_range(0, 3) == 0) enable = ~enable;
            repeat ($urandom_range(0, 30)) tick();
        end
        enable = 1'b1;
        drain("drain_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
